fma_special_case_unit: RTL and testbench

Parametrised, pipelined successor to the combinational special-case detector for the FMA datapath. Classifies operands A, B and C, and resolves every fused-multiply-add result that needs no arithmetic: NaN propagation, invalid operations, infinities, zero-sign rules and the exact-addend case. The operation mode follows the RISC-V FMADD/FMSUB/FNMSUB/FNMADD encoding. Sits beside the multiplier/aligner front end; when special_o=1, downstream selects result_o and discards the datapath result.

---
 rtl/fma_special_case_unit.sv | 250 +++++++++++++++++++++++++
 tb/tb_fma_special_case_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_special_case_unit.sv
// ---------------------------------------------------------------------------
// fma_special_case_unit
//
// Two-stage pipelined special-case resolver for a fused multiply-add
// R = +/-(A*B) +/- C. It classifies the three operands and produces the final
// result whenever no arithmetic is needed: NaN propagation, invalid
// operations, infinities, signed-zero rules and the exact-addend case
// (product is zero, C finite and nonzero). When special_o=1 the downstream
// mux takes result_o and drops the datapath result.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   valid_i / ready_o  input handshake (ready_o may depend on ready_i)
//   A_i, B_i, C_i      multiplicand, multiplier, addend (IEEE-754 encoding)
//   op_i               bit1 negates the product, bit0 negates the addend
//   rm_i               RISC-V rounding mode (only RDN affects zero signs here)
//   valid_o / ready_i  output handshake; outputs hold while stalled
//   special_o          result_o is the final FMA result
//   result_o           resolved result, zero when special_o=0
//   nv_o               invalid-operation flag
//   den_o              {A,B,C} subnormal flags
// ---------------------------------------------------------------------------
module fma_special_case_unit #(
   parameter int PARM_EXP  = 8,
   parameter int PARM_MANT = 23,
   parameter int PARM_XLEN = 1 + PARM_EXP + PARM_MANT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [PARM_XLEN-1:0] A_i,
   input  logic [PARM_XLEN-1:0] B_i,
   input  logic [PARM_XLEN-1:0] C_i,
   input  logic [1:0]           op_i,
   input  logic [2:0]           rm_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 special_o,
   output logic [PARM_XLEN-1:0] result_o,
   output logic                 nv_o,
   output logic [2:0]           den_o
);

   // Canonical quiet NaN: positive, exponent all ones, only the mantissa MSB set.
   localparam logic [PARM_XLEN-1:0] CANON_NAN =
      {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};

   typedef struct packed {
      logic zero;
      logic sub;
      logic inf;
      logic nan;
      logic snan;
   } cls_t;

   // Operand classification from the raw encoding.
   function automatic cls_t classify(input logic [PARM_XLEN-1:0] x);
      cls_t                 c;
      logic [PARM_EXP-1:0]  e;
      logic [PARM_MANT-1:0] m;
      logic                 exp_zero;
      logic                 exp_full;
      logic                 mant_zero;
      e         = x[PARM_XLEN-2 -: PARM_EXP];
      m         = x[PARM_MANT-1:0];
      exp_zero  = (e == {PARM_EXP{1'b0}});
      exp_full  = (e == {PARM_EXP{1'b1}});
      mant_zero = (m == {PARM_MANT{1'b0}});
      c.zero    = exp_zero & mant_zero;
      c.sub     = exp_zero & ~mant_zero;
      c.inf     = exp_full & mant_zero;
      c.nan     = exp_full & ~mant_zero;
      c.snan    = c.nan & ~m[PARM_MANT-1];
      return c;
   endfunction

   // ---------------- stage 1 state ----------------
   logic                 s1_valid_q, s1_valid_d;
   logic [PARM_XLEN-1:0] s1_a_q, s1_a_d;
   logic [PARM_XLEN-1:0] s1_b_q, s1_b_d;
   logic [PARM_XLEN-1:0] s1_c_q, s1_c_d;
   logic [1:0]           s1_op_q, s1_op_d;
   logic [2:0]           s1_rm_q, s1_rm_d;
   cls_t                 s1_ca_q, s1_ca_d;
   cls_t                 s1_cb_q, s1_cb_d;
   cls_t                 s1_cc_q, s1_cc_d;

   // ---------------- stage 2 state ----------------
   logic                 s2_valid_q, s2_valid_d;
   logic                 s2_special_q, s2_special_d;
   logic [PARM_XLEN-1:0] s2_result_q, s2_result_d;
   logic                 s2_nv_q, s2_nv_d;
   logic [2:0]           s2_den_q, s2_den_d;

   // ---------------- handshake ----------------
   logic s2_adv_s;

   assign s2_adv_s = ~s2_valid_q | ready_i;
   assign ready_o  = ~s1_valid_q | s2_adv_s;

   // Stage 1 capture: load new operands whenever the stage can accept.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_c_d     = s1_c_q;
      s1_op_d    = s1_op_q;
      s1_rm_d    = s1_rm_q;
      s1_ca_d    = s1_ca_q;
      s1_cb_d    = s1_cb_q;
      s1_cc_d    = s1_cc_q;
      if (ready_o) begin
         // Any held entry moves to stage 2 this cycle, so stage 1 simply
         // takes whatever is offered (or becomes empty).
         s1_valid_d = valid_i;
         if (valid_i) begin
            s1_a_d  = A_i;
            s1_b_d  = B_i;
            s1_c_d  = C_i;
            s1_op_d = op_i;
            s1_rm_d = rm_i;
            s1_ca_d = classify(A_i);
            s1_cb_d = classify(B_i);
            s1_cc_d = classify(C_i);
         end else begin
            s1_a_d  = s1_a_q;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // ---------------- resolution (from stage-1 registers) ----------------
   logic                 ps_s;
   logic                 cs_s;
   logic                 prod_inf_s;
   logic                 prod_zero_s;
   logic                 res_special_s;
   logic [PARM_XLEN-1:0] res_result_s;
   logic                 res_nv_s;

   // Priority-ordered special-case resolution.
   always_comb begin
      ps_s          = s1_a_q[PARM_XLEN-1] ^ s1_b_q[PARM_XLEN-1] ^ s1_op_q[1];
      cs_s          = s1_c_q[PARM_XLEN-1] ^ s1_op_q[0];
      prod_inf_s    = s1_ca_q.inf | s1_cb_q.inf;
      prod_zero_s   = s1_ca_q.zero | s1_cb_q.zero;
      res_special_s = 1'b1;
      res_result_s  = {PARM_XLEN{1'b0}};
      res_nv_s      = 1'b0;
      if (s1_ca_q.snan | s1_cb_q.snan | s1_cc_q.snan) begin
         res_result_s = CANON_NAN;
         res_nv_s     = 1'b1;
      end else if ((s1_ca_q.inf & s1_cb_q.zero) | (s1_ca_q.zero & s1_cb_q.inf)) begin
         // inf*0 is invalid even when the addend is a quiet NaN.
         res_result_s = CANON_NAN;
         res_nv_s     = 1'b1;
      end else if (s1_ca_q.nan | s1_cb_q.nan | s1_cc_q.nan) begin
         res_result_s = CANON_NAN;
      end else if (prod_inf_s & s1_cc_q.inf & (ps_s != cs_s)) begin
         res_result_s = CANON_NAN;
         res_nv_s     = 1'b1;
      end else if (prod_inf_s) begin
         res_result_s = {ps_s, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
      end else if (s1_cc_q.inf) begin
         res_result_s = {cs_s, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
      end else if (prod_zero_s & s1_cc_q.zero) begin
         // Exact zero sum: opposite signs give +0 except in round-down.
         if (ps_s == cs_s) begin
            res_result_s = {ps_s, {(PARM_XLEN-1){1'b0}}};
         end else begin
            res_result_s = {(s1_rm_q == 3'b010), {(PARM_XLEN-1){1'b0}}};
         end
      end else if (prod_zero_s) begin
         // Zero product: the (possibly negated) addend is the exact result.
         res_result_s = {cs_s, s1_c_q[PARM_XLEN-2:0]};
      end else begin
         res_special_s = 1'b0;
      end
   end

   // Stage 2 load: resolved outputs advance when the output register is free.
   always_comb begin
      s2_valid_d   = s2_valid_q;
      s2_special_d = s2_special_q;
      s2_result_d  = s2_result_q;
      s2_nv_d      = s2_nv_q;
      s2_den_d     = s2_den_q;
      if (s2_adv_s) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_special_d = res_special_s;
            s2_result_d  = res_result_s;
            s2_nv_d      = res_nv_s;
            s2_den_d     = {s1_ca_q.sub, s1_cb_q.sub, s1_cc_q.sub};
         end else begin
            // Bubble: present clean zeros rather than stale data.
            s2_special_d = 1'b0;
            s2_result_d  = {PARM_XLEN{1'b0}};
            s2_nv_d      = 1'b0;
            s2_den_d     = 3'b000;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end
   end

   // Pipeline registers with asynchronous reset discarding all in-flight entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_a_q       <= {PARM_XLEN{1'b0}};
         s1_b_q       <= {PARM_XLEN{1'b0}};
         s1_c_q       <= {PARM_XLEN{1'b0}};
         s1_op_q      <= 2'b00;
         s1_rm_q      <= 3'b000;
         s1_ca_q      <= '0;
         s1_cb_q      <= '0;
         s1_cc_q      <= '0;
         s2_valid_q   <= 1'b0;
         s2_special_q <= 1'b0;
         s2_result_q  <= {PARM_XLEN{1'b0}};
         s2_nv_q      <= 1'b0;
         s2_den_q     <= 3'b000;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_c_q       <= s1_c_d;
         s1_op_q      <= s1_op_d;
         s1_rm_q      <= s1_rm_d;
         s1_ca_q      <= s1_ca_d;
         s1_cb_q      <= s1_cb_d;
         s1_cc_q      <= s1_cc_d;
         s2_valid_q   <= s2_valid_d;
         s2_special_q <= s2_special_d;
         s2_result_q  <= s2_result_d;
         s2_nv_q      <= s2_nv_d;
         s2_den_q     <= s2_den_d;
      end
   end

   assign valid_o   = s2_valid_q;
   assign special_o = s2_special_q;
   assign result_o  = s2_result_q;
   assign nv_o      = s2_nv_q;
   assign den_o     = s2_den_q;

endmodule

// File: tb/tb_fma_special_case_unit.sv
// Testbench for fma_special_case_unit (binary32 configuration): directed
// vector table, stall/ordering and mid-stream reset sequences, and random
// traffic against a behavioural reference model.
module tb_fma_special_case_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [31:0] a_i = 32'h0;
   logic [31:0] b_i = 32'h0;
   logic [31:0] c_i = 32'h0;
   logic [1:0]  op_i = 2'b00;
   logic [2:0]  rm_i = 3'b000;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic        special_o;
   logic [31:0] result_o;
   logic        nv_o;
   logic [2:0]  den_o;

   fma_special_case_unit #(.PARM_EXP(8), .PARM_MANT(23)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
      .A_i(a_i), .B_i(b_i), .C_i(c_i), .op_i(op_i), .rm_i(rm_i),
      .valid_o(valid_o), .ready_i(ready_i), .special_o(special_o),
      .result_o(result_o), .nv_o(nv_o), .den_o(den_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int pops   = 0;

   typedef struct packed {
      logic        sp;
      logic        nv;
      logic [2:0]  den;
      logic [31:0] res;
   } exp_t;

   typedef struct {
      logic [31:0] a, b, c;
      logic [1:0]  op;
      logic [2:0]  rm;
      exp_t        e;
   } vec_t;

   exp_t sb_q[$];
   exp_t prev_out;
   logic prev_stall = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Operand kinds: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN
   function automatic int kind_of(input logic [31:0] x);
      int e;
      int m;
      e = int'(x[30:23]);
      m = int'(x[22:0]);
      if (e == 255) return (m == 0) ? 3 : (x[22] ? 4 : 5);
      if (e == 0) return (m == 0) ? 0 : 1;
      return 2;
   endfunction

   function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [1:0] op,
                                      input logic [2:0] rm);
      exp_t r;
      int   ka, kb, kc;
      logic ps, cs, pinf, pzero;
      ka = kind_of(a); kb = kind_of(b); kc = kind_of(c);
      ps = a[31] ^ b[31] ^ op[1];
      cs = c[31] ^ op[0];
      pinf  = (ka == 3) || (kb == 3);
      pzero = (ka == 0) || (kb == 0);
      r.den = {ka == 1, kb == 1, kc == 1};
      r.sp  = 1'b1;
      r.nv  = 1'b0;
      r.res = 32'h0;
      if (ka == 5 || kb == 5 || kc == 5) begin
         r.res = 32'h7fc00000; r.nv = 1'b1;
      end else if ((ka == 3 && kb == 0) || (ka == 0 && kb == 3)) begin
         r.res = 32'h7fc00000; r.nv = 1'b1;
      end else if (ka == 4 || kb == 4 || kc == 4) begin
         r.res = 32'h7fc00000;
      end else if (pinf && kc == 3 && ps != cs) begin
         r.res = 32'h7fc00000; r.nv = 1'b1;
      end else if (pinf) begin
         r.res = {ps, 31'h7f800000};
      end else if (kc == 3) begin
         r.res = {cs, 31'h7f800000};
      end else if (pzero && kc == 0) begin
         r.res = {(ps == cs) ? ps : (rm == 3'b010), 31'h0};
      end else if (pzero) begin
         r.res = {cs, c[30:0]};
      end else begin
         r.sp = 1'b0;
      end
      return r;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 11))
         0: return 32'h00000000;
         1: return 32'h80000000;
         2: return 32'h7f800000;
         3: return 32'hff800000;
         4: return 32'h7fc00000;
         5: return 32'h7fa00000;
         6: return 32'h3f800000;
         7: return 32'h00000001;
         8: return 32'h80400000;
         9: return 32'hffc12345;
         default: return $urandom();
      endcase
   endfunction

   // Evaluate this cycle's transfers (called mid-cycle, inputs stable).
   task automatic sb_step();
      exp_t e;
      if (prev_stall)
         chk("hold", {27'h0, valid_o, special_o, nv_o, den_o, result_o}, {27'h0, 1'b1, prev_out});
      if (valid_o && ready_i) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_output", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            pops++;
            chk("sb_output", {27'h0, special_o, nv_o, den_o, result_o}, {27'h0, e});
         end
      end
      if (valid_i && ready_o) sb_q.push_back(ref_model(a_i, b_i, c_i, op_i, rm_i));
      prev_stall = valid_o && !ready_i;
      prev_out   = {special_o, nv_o, den_o, result_o};
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   vec_t vecs[$];

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                               input logic [1:0] op, input logic [2:0] rm, input logic sp,
                               input logic [31:0] res, input logic nv, input logic [2:0] den);
      vec_t v;
      v.a = a; v.b = b; v.c = c; v.op = op; v.rm = rm;
      v.e.sp = sp; v.e.res = res; v.e.nv = nv; v.e.den = den;
      return v;
   endfunction

   initial begin
      int   lat;
      int   fed;
      logic [31:0] stall_c [5];

      vecs.push_back(mk(32'h7f800000, 32'h00000000, 32'h3f800000, 2'b00, 3'b000, 1'b1, 32'h7fc00000, 1'b1, 3'b000));
      vecs.push_back(mk(32'h7fa00000, 32'h3f800000, 32'h3f800000, 2'b00, 3'b000, 1'b1, 32'h7fc00000, 1'b1, 3'b000));
      vecs.push_back(mk(32'h7fc00001, 32'h3f800000, 32'h3f800000, 2'b00, 3'b000, 1'b1, 32'h7fc00000, 1'b0, 3'b000));
      vecs.push_back(mk(32'h7f800000, 32'h3f800000, 32'h7f800000, 2'b01, 3'b000, 1'b1, 32'h7fc00000, 1'b1, 3'b000));
      vecs.push_back(mk(32'h7f800000, 32'h3f800000, 32'h7f800000, 2'b00, 3'b000, 1'b1, 32'h7f800000, 1'b0, 3'b000));
      vecs.push_back(mk(32'h7f800000, 32'h3f800000, 32'h7f800000, 2'b10, 3'b000, 1'b1, 32'h7fc00000, 1'b1, 3'b000));
      vecs.push_back(mk(32'h80000000, 32'h3f800000, 32'h00000000, 2'b00, 3'b000, 1'b1, 32'h00000000, 1'b0, 3'b000));
      vecs.push_back(mk(32'h80000000, 32'h3f800000, 32'h00000000, 2'b00, 3'b010, 1'b1, 32'h80000000, 1'b0, 3'b000));
      vecs.push_back(mk(32'h00000000, 32'h40000000, 32'h40400000, 2'b11, 3'b000, 1'b1, 32'hc0400000, 1'b0, 3'b000));
      vecs.push_back(mk(32'h3f800000, 32'h40000000, 32'h00000001, 2'b00, 3'b000, 1'b0, 32'h00000000, 1'b0, 3'b001));
      vecs.push_back(mk(32'h00000000, 32'hff800000, 32'h7fc00000, 2'b00, 3'b000, 1'b1, 32'h7fc00000, 1'b1, 3'b000));
      vecs.push_back(mk(32'hff800000, 32'h3f800000, 32'h3f800000, 2'b11, 3'b000, 1'b1, 32'h7f800000, 1'b0, 3'b000));
      vecs.push_back(mk(32'h80000000, 32'h80000000, 32'h00000000, 2'b11, 3'b000, 1'b1, 32'h80000000, 1'b0, 3'b000));
      vecs.push_back(mk(32'h00000000, 32'h3f800000, 32'h80000005, 2'b00, 3'b000, 1'b1, 32'h80000005, 1'b0, 3'b001));
      vecs.push_back(mk(32'h00000000, 32'h00400000, 32'h3f800000, 2'b00, 3'b000, 1'b1, 32'h3f800000, 1'b0, 3'b010));
      vecs.push_back(mk(32'h3f800000, 32'h40000000, 32'h7f800000, 2'b01, 3'b000, 1'b1, 32'hff800000, 1'b0, 3'b000));

      // Reset state
      #3;
      chk("reset_outputs", {58'h0, valid_o, special_o, nv_o, den_o}, 64'h0);
      chk("reset_result", {32'h0, result_o}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready_after_reset", {63'h0, ready_o}, 64'd1);

      // Directed vector table, one at a time, with latency check
      ready_i = 1'b1;
      foreach (vecs[i]) begin
         @(negedge clk);
         a_i = vecs[i].a; b_i = vecs[i].b; c_i = vecs[i].c;
         op_i = vecs[i].op; rm_i = vecs[i].rm; valid_i = 1'b1;
         next_cycle();
         valid_i = 1'b0;
         lat = 1;
         while (!valid_o && lat < 6) begin
            next_cycle();
            lat++;
         end
         chk($sformatf("latency_v%0d", i), 64'(lat), 64'd2);
         chk($sformatf("vec%0d", i), {27'h0, special_o, nv_o, den_o, result_o}, {27'h0, vecs[i].e});
      end
      next_cycle();

      // Stall: five back-to-back entries, ready_i low for 4 cycles
      for (int k = 0; k < 5; k++) stall_c[k] = 32'h00000010 + 32'(k);
      ready_i = 1'b0;
      fed = 0;
      pops = 0;
      op_i = 2'b00; rm_i = 3'b000;
      for (int cyc = 0; cyc < 30 && (fed < 5 || sb_q.size() != 0); cyc++) begin
         if (cyc == 4) ready_i = 1'b1;
         valid_i = (fed < 5);
         a_i = 32'h00000000; b_i = 32'h3f800000;
         c_i = (fed < 5) ? stall_c[fed] : 32'h0;
         #1;
         if (cyc == 2 || cyc == 3) chk($sformatf("ready_full_c%0d", cyc), {63'h0, ready_o}, 64'd0);
         if (valid_i && ready_o) fed++;
         sb_step();
         next_cycle();
      end
      valid_i = 1'b0;
      chk("stall_all_out", 64'(pops), 64'd5);
      chk("stall_queue_empty", 64'(sb_q.size()), 64'd0);

      // Mid-stream reset with two entries in flight
      ready_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         valid_i = 1'b1; a_i = 32'h7f800000; b_i = 32'h3f800000; c_i = 32'h0;
         next_cycle();
      end
      valid_i = 1'b0;
      #1;
      chk("inflight_before_reset", {63'h0, valid_o}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_valid", {63'h0, valid_o}, 64'd0);
      chk("async_reset_outs", {27'h0, special_o, nv_o, den_o, result_o}, 64'h0);
      sb_q.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("no_stale_c%0d", k), {62'h0, valid_o, ready_o}, 64'd1);
         next_cycle();
      end

      // Random traffic against the reference model
      for (int cyc = 0; cyc < 600; cyc++) begin
         valid_i = ($urandom_range(0, 3) != 0);
         ready_i = ($urandom_range(0, 2) != 0);
         a_i = pick(); b_i = pick(); c_i = pick();
         op_i = 2'($urandom_range(0, 3));
         rm_i = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'($urandom_range(0, 7));
         #1;
         sb_step();
         next_cycle();
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         #1;
         sb_step();
         next_cycle();
      end
      chk("random_drained", 64'(sb_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
